// File: rtl/ysyx_22050710_ifu_pkg.sv
// Shared IFU definitions: widths, reset PC default, FSM encoding, fetch helpers.
// Pure declarations; no timing or flow control of its own.
package ysyx_22050710_ifu_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_REQ   = 2'b01,
      ST_VALID = 2'b10,
      ST_ERR   = 2'b11
   } ifu_state_t;

   // Memory is 64 bits wide, so fetches always use the doubleword-aligned address.
   function automatic logic [XLEN-1:0] fetch_addr(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:3], 3'b000};
   endfunction

   function automatic logic [ILEN-1:0] pick_half(input logic [XLEN-1:0] pc,
                                                 input logic [XLEN-1:0] data);
      return pc[2] ? data[63:32] : data[31:0];
   endfunction

endpackage

// File: rtl/ysyx_22050710_inst_buf.sv
// Holding register for the fetched instruction and its PC; updates one cycle after load/clear.
// No handshake of its own: the owner decides when to load or clear.
module ysyx_22050710_inst_buf
   import ysyx_22050710_ifu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            clear,
   input  logic [ILEN-1:0] new_inst,
   input  logic [XLEN-1:0] new_pc,
   output logic [ILEN-1:0] inst,
   output logic [XLEN-1:0] pc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst <= '0;
         pc   <= RESET_PC;
      end else if (clear) begin
         inst <= '0;
         pc   <= RESET_PC;
      end else if (load) begin
         inst <= new_inst;
         pc   <= new_pc;
      end
   end

endmodule

// File: rtl/ysyx_22050710_ifu.sv
// Instruction fetch unit: ack in cycle N gives o_inst_valid in N+1; at most one instruction per two cycles.
// Holds o_inst/o_pc until decode takes them; misaligned redirects trap to ERR when YSYX_22050710_IFU_MISALIGN_EN is defined.
module ysyx_22050710_ifu
   import ysyx_22050710_ifu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
)
(
   input  logic            i_clk,
   input  logic            i_rst,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_ack,
   input  logic [XLEN-1:0] i_imem_rdata,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic [ILEN-1:0] o_inst,
   output logic [XLEN-1:0] o_pc,
   output logic            o_inst_valid,
`ifdef YSYX_22050710_IFU_MISALIGN_EN
   output logic            o_misalign,
`endif
   input  logic            i_inst_ready
);

   ifu_state_t      state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic            kill, kill_nxt;
   logic            buf_load, buf_clear;
   logic            xfer;
   logic [XLEN-1:0] redir_tgt;
   logic            redir_bad;

`ifdef YSYX_22050710_IFU_MISALIGN_EN
   assign redir_tgt  = i_redirect_pc;
   assign redir_bad  = |i_redirect_pc[1:0];
   assign o_misalign = (state == ST_ERR);
`else
   logic unused_redir_lsb;
   assign unused_redir_lsb = ^i_redirect_pc[1:0];
   assign redir_tgt = {i_redirect_pc[XLEN-1:2], 2'b00};
   assign redir_bad = 1'b0;
`endif

   assign o_imem_req   = (state == ST_REQ);
   assign o_imem_addr  = fetch_addr(pc);
   assign o_inst_valid = (state == ST_VALID) & ~i_redirect;
   assign xfer         = o_inst_valid & i_inst_ready;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      kill_nxt  = kill;
      buf_load  = 1'b0;
      buf_clear = 1'b0;

      case (state)
         ST_IDLE:  state_nxt = ST_REQ;
         ST_REQ: begin
            // A killed ack belongs to a request made before a redirect.
            if (i_imem_ack) begin
               if (kill) begin
                  kill_nxt = 1'b0;
               end else if (!i_redirect) begin
                  buf_load  = 1'b1;
                  state_nxt = ST_VALID;
               end
            end
         end
         ST_VALID: begin
            if (xfer) begin
               pc_nxt    = pc + 64'd4;
               state_nxt = ST_REQ;
            end
         end
         ST_ERR: begin
            if (i_imem_ack) kill_nxt = 1'b0;
         end
      endcase

      if (i_redirect) begin
         pc_nxt = redir_tgt;
         if (state == ST_REQ && !i_imem_ack) kill_nxt = 1'b1;
         if (state == ST_VALID) buf_clear = 1'b1;
         if (state != ST_IDLE) state_nxt = ST_REQ;
         if (redir_bad) state_nxt = ST_ERR;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_IDLE;
         pc    <= RESET_PC;
         kill  <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         kill  <= kill_nxt;
      end
   end

   ysyx_22050710_inst_buf #(
      .RESET_PC (RESET_PC)
   ) u_inst_buf (
      .clk      (i_clk),
      .rst      (i_rst),
      .load     (buf_load),
      .clear    (buf_clear),
      .new_inst (pick_half(pc, i_imem_rdata)),
      .new_pc   (pc),
      .inst     (o_inst),
      .pc       (o_pc)
   );

endmodule

// File: tb/tb_ysyx_22050710_ifu.sv
// Directed bench for ysyx_22050710_ifu: memory responses driven step by step, delivered instructions scoreboarded.
module tb_ysyx_22050710_ifu;

   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [63:0] imem_rdata;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic [31:0] inst;
   logic [63:0] pc_out;
   logic        inst_valid;
   logic        inst_ready;
`ifdef YSYX_22050710_IFU_MISALIGN_EN
   logic        misalign;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [95:0] sb[$];
   logic [63:0] exp_pc;

   always #5 clk = ~clk;

   ysyx_22050710_ifu dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_ack    (imem_ack),
      .i_imem_rdata  (imem_rdata),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_inst        (inst),
      .o_pc          (pc_out),
      .o_inst_valid  (inst_valid),
`ifdef YSYX_22050710_IFU_MISALIGN_EN
      .o_misalign    (misalign),
`endif
      .i_inst_ready  (inst_ready)
   );

   // Memory contents: each 32-bit half is derived from the doubleword address.
   function automatic logic [63:0] mem_word(input logic [63:0] a);
      return {a[31:0] ^ 32'h2222_2222, a[31:0] ^ 32'h1111_1111};
   endfunction

   function automatic logic [31:0] exp_inst(input logic [63:0] p);
      logic [31:0] base;
      base = {p[31:3], 3'b000};
      return p[2] ? (base ^ 32'h2222_2222) : (base ^ 32'h1111_1111);
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic serve(input int dly, input bit keep);
      for (int i = 0; i < dly; i++) begin
         #1;
         chk("req_wait", {63'b0, imem_req}, 64'd1);
         chk("addr_wait", imem_addr, {exp_pc[63:3], 3'b000});
         step();
      end
      #1;
      chk("req", {63'b0, imem_req}, 64'd1);
      chk("addr", imem_addr, {exp_pc[63:3], 3'b000});
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      if (keep) sb.push_back({exp_pc, exp_inst(exp_pc)});
      step();
      imem_ack   = 1'b0;
      imem_rdata = {$urandom, $urandom};
   endtask

   task automatic take();
      logic [95:0] e;
      inst_ready = 1'b1;
      #1;
      chk("valid", {63'b0, inst_valid}, 64'd1);
      chk("sb_nonempty", {63'b0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("o_pc", pc_out, e[95:32]);
         chk("o_inst", {32'b0, inst}, {32'b0, e[31:0]});
      end
      step();
      inst_ready = 1'b0;
      exp_pc     = exp_pc + 64'd4;
   endtask

   task automatic redir_in_valid(input logic [63:0] tgt);
      inst_ready  = 1'b1;
      redirect    = 1'b1;
      redirect_pc = tgt;
      #1;
      chk("valid_gated", {63'b0, inst_valid}, 64'd0);
      step();
      redirect   = 1'b0;
      inst_ready = 1'b0;
      void'(sb.pop_front());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
      redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      exp_pc = RST_PC;
      step();
      step();
      chk("rst_req", {63'b0, imem_req}, 64'd0);
      chk("rst_valid", {63'b0, inst_valid}, 64'd0);
      chk("rst_inst", {32'b0, inst}, 64'd0);
      chk("rst_pc", pc_out, RST_PC);
      rst = 1'b0;
      #1;
      chk("idle_req", {63'b0, imem_req}, 64'd0);
      step();

      // In-order fetch with one-cycle memory latency.
      for (int k = 0; k < 3; k++) begin
         serve(1, 1'b1);
         take();
      end

      // Decode stalls for five cycles.
      serve(0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("stall_valid", {63'b0, inst_valid}, 64'd1);
         chk("stall_req", {63'b0, imem_req}, 64'd0);
         chk("stall_pc", pc_out, sb[0][95:32]);
         chk("stall_inst", {32'b0, inst}, {32'b0, sb[0][31:0]});
         step();
      end
      take();

      // Redirect while a request is outstanding; its late ack is dropped.
      redirect = 1'b1; redirect_pc = 64'h8000_1000;
      #1;
      chk("kill_req", {63'b0, imem_req}, 64'd1);
      step();
      redirect = 1'b0;
      exp_pc   = 64'h8000_1000;
      serve(2, 1'b0);
      serve(1, 1'b1);
      take();

      // Redirect colliding with a ready transfer.
      serve(0, 1'b1);
      redir_in_valid(64'h8000_2000);
      exp_pc = 64'h8000_2000;
      serve(0, 1'b1);
      take();

      // Redirect coincident with an ack.
      imem_ack = 1'b1; imem_rdata = {$urandom, $urandom};
      redirect = 1'b1; redirect_pc = 64'h8000_3000;
      step();
      imem_ack = 1'b0; redirect = 1'b0;
      exp_pc   = 64'h8000_3000;
      serve(0, 1'b1);
      take();

      // Back-to-back redirects: the second target wins.
      redirect = 1'b1; redirect_pc = 64'h8000_4000;
      step();
      redirect_pc = 64'h8000_5000;
      step();
      redirect = 1'b0;
      exp_pc   = 64'h8000_5000;
      serve(0, 1'b0);
      serve(0, 1'b1);
      take();

      serve(0, 1'b1);
`ifdef YSYX_22050710_IFU_MISALIGN_EN
      redir_in_valid(64'h8000_0002);
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("err_misalign", {63'b0, misalign}, 64'd1);
         chk("err_req", {63'b0, imem_req}, 64'd0);
         chk("err_valid", {63'b0, inst_valid}, 64'd0);
         step();
      end
      redirect = 1'b1; redirect_pc = 64'h8000_0010;
      step();
      redirect = 1'b0;
      #1;
      chk("err_exit", {63'b0, misalign}, 64'd0);
      exp_pc = 64'h8000_0010;
`else
      redir_in_valid(64'h8000_6006);
      exp_pc = 64'h8000_6004;
`endif
      serve(0, 1'b1);
      take();

      // PC wraps past the top of the address space.
      serve(0, 1'b1);
      redir_in_valid(64'hFFFF_FFFF_FFFF_FFFC);
      exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      serve(0, 1'b1);
      take();
      chk("wrap_pc", exp_pc, 64'd0);
      serve(0, 1'b1);
      take();

      // Reset mid-request, stray ack in the following cycle.
      #1;
      chk("pre_rst_req", {63'b0, imem_req}, 64'd1);
      rst = 1'b1;
      step();
      chk("mid_rst_req", {63'b0, imem_req}, 64'd0);
      chk("mid_rst_pc", pc_out, RST_PC);
      rst = 1'b0;
      imem_ack = 1'b1; imem_rdata = {$urandom, $urandom};
      #1;
      chk("post_rst_idle", {63'b0, imem_req}, 64'd0);
      chk("post_rst_valid", {63'b0, inst_valid}, 64'd0);
      step();
      imem_ack = 1'b0;
      exp_pc   = RST_PC;
      serve(1, 1'b1);
      take();

      // Redirect during the IDLE cycle.
      rst = 1'b1;
      step();
      rst = 1'b0;
      redirect = 1'b1; redirect_pc = 64'h8000_7000;
      #1;
      chk("idle_redir_req", {63'b0, imem_req}, 64'd0);
      step();
      redirect = 1'b0;
      exp_pc   = 64'h8000_7000;
      serve(0, 1'b1);
      take();

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
